// File: rtl/modsub_arb_pkg.sv
// modsub_arb_pkg: shared types and default sizes for modsub_arbiter.
// The operand struct is sized from the default widths.
package modsub_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] a;
    logic [DEF_DATA_WIDTH-1:0] b;
    logic [DEF_DATA_WIDTH-1:0] modulant;
    logic [DEF_ID_W-1:0]       id;
  } operand_t;

endpackage

// File: rtl/modsub_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               slot;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        grant_idx   = IDX_W'(slot);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance)
      ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ?
             '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/modsub_arbiter.sv
// modsub_arbiter: round-robin shared (a - b) mod modulant datapath.
// Define MODSUB_ARB_INPUT_REG_EN for a registered operand stage.
module modsub_arbiter
  import modsub_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               modulant,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [ID_W-1:0]                     rsp_id
);

  state_t                state;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gidx;
  logic                  in_ready;
  logic                  accept;
  logic                  load;
  logic                  out_free;
  logic [DATA_WIDTH-1:0] ld_a;
  logic [DATA_WIDTH-1:0] ld_b;
  logic [DATA_WIDTH-1:0] ld_m;
  logic [ID_W-1:0]       ld_id;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] result;

  assign out_free  = (state == EMPTY) || rsp_ready;
  assign req_ready = (rst_n && in_ready) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (gidx)
  );

`ifdef MODSUB_ARB_INPUT_REG_EN
  operand_t stage;
  logic     stage_valid;

  assign in_ready = !stage_valid || out_free;
  assign load     = stage_valid && out_free;
  assign ld_a     = stage.a;
  assign ld_b     = stage.b;
  assign ld_m     = stage.modulant;
  assign ld_id    = stage.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage       <= '0;
    end else if (accept) begin
      stage_valid    <= 1'b1;
      stage.a        <= req_a[gidx];
      stage.b        <= req_b[gidx];
      stage.modulant <= modulant;
      stage.id       <= gidx;
    end else if (load) begin
      stage_valid <= 1'b0;
    end
  end
`else
  assign in_ready = out_free;
  assign load     = accept;
  assign ld_a     = req_a[gidx];
  assign ld_b     = req_b[gidx];
  assign ld_m     = modulant;
  assign ld_id    = gidx;
`endif

  // Borrow out of the widened difference selects the wrap-around add.
  assign diff   = {1'b0, ld_a} - {1'b0, ld_b};
  assign result = diff[DATA_WIDTH] ?
                  diff[DATA_WIDTH-1:0] + ld_m :
                  diff[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (load) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_data  <= result;
            rsp_id    <= ld_id;
          end
        end
        FULL: begin
          if (load) begin
            rsp_data <= result;
            rsp_id   <= ld_id;
          end else if (rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_modsub_arbiter.sv
// tb_modsub_arbiter: directed and random checks of modsub_arbiter
// against an elastic-pipeline scoreboard model.
module tb_modsub_arbiter;

`ifdef MODSUB_ARB_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           modulant;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [3:0][7:0]      req_a;
  logic [3:0][7:0]      req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic [1:0]           rsp_id;

  always #5 clk = ~clk;

  modsub_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .ID_W       (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .modulant  (modulant),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  typedef struct {
    bit v;
    int d;
    int id;
  } slot_t;

  slot_t      sl[LAT];
  int         ptr_m;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_acc = 0;
  int         n_pop = 0;
  bit         last_acc;
  int         last_g;
  logic       obs_v;
  logic [7:0] obs_d;
  logic [1:0] obs_id;
  logic [3:0] obs_rr;
  bit [3:0]   pend;
  int         ids[$];
  logic [7:0] cap_d;
  logic [1:0] cap_id;

  function automatic int exp_sub(int a, int b, int m);
    return (a >= b) ? (a - b) : ((a - b + m) & 255);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < LAT; k++) sl[k] = '{0, 0, 0};
    ptr_m = 0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [3:0] v, input bit rdy);
    int g;
    bit any;
    bit fr[LAT];
    logic [3:0] er;
    bit acc;
    req_valid = v;
    rsp_ready = rdy;
    #1;
    any = 0;
    g = 0;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr_m + i) % 4;
      if (!any && v[j]) begin
        any = 1;
        g = j;
      end
    end
    fr[LAT-1] = !sl[LAT-1].v || rdy;
    for (int k = LAT - 2; k >= 0; k--) fr[k] = !sl[k].v || fr[k+1];
    acc = any && fr[0];
    er = acc ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(sl[LAT-1].v));
    if (sl[LAT-1].v) begin
      chk("rsp_data", 32'(rsp_data), 32'(sl[LAT-1].d));
      chk("rsp_id", 32'(rsp_id), 32'(sl[LAT-1].id));
    end
    obs_v  = rsp_valid;
    obs_d  = rsp_data;
    obs_id = rsp_id;
    obs_rr = req_ready;
    if (rsp_valid === 1'b1 && rdy) n_pop++;
    if (sl[LAT-1].v && rdy) sl[LAT-1].v = 0;
    for (int k = LAT - 1; k > 0; k--) begin
      if (!sl[k].v && sl[k-1].v) begin
        sl[k] = sl[k-1];
        sl[k-1].v = 0;
      end
    end
    if (acc) begin
      sl[0].v  = 1;
      sl[0].d  = exp_sub(int'(req_a[g]), int'(req_b[g]), int'(modulant));
      sl[0].id = g;
      ptr_m = (g + 1) % 4;
      n_acc++;
    end
    last_acc = acc;
    last_g   = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one(input int p, input int a, input int b,
                         input int m, input int expd);
    req_a[p] = 8'(a);
    req_b[p] = 8'(b);
    modulant = 8'(m);
    step(4'b0001 << p, 1'b1);
    repeat (LAT) step(4'b0000, 1'b1);
    chk("one_valid", 32'(obs_v), 32'd1);
    chk("one_data", 32'(obs_d), 32'(expd));
    chk("one_id", 32'(obs_id), 32'(p));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    modulant  = 8'd17;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 8'($urandom);
      req_b[i] = 8'($urandom);
    end
    pend = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all ports valid, consumer always ready.
    for (int n = 0; n < 6 + LAT; n++) begin
      step(4'hF, 1'b1);
      if (obs_v === 1'b1) ids.push_back(int'(obs_id));
      if (last_acc) begin
        req_a[last_g] = 8'($urandom);
        req_b[last_g] = 8'($urandom);
      end
    end
    chk("fair_count", 32'(ids.size()), 32'd6);
    for (int i = 0; i < 6 && i < ids.size(); i++)
      chk("fair_id", 32'(ids[i]), 32'(i % 4));

    // Directed arithmetic cases.
    run_one(0, 3, 5, 17, 15);
    run_one(2, 10, 4, 17, 6);
    run_one(1, 42, 42, 251, 0);
    run_one(3, 0, 250, 251, 1);

    // Backpressure with all ports valid.
    for (int n = 0; n < LAT + 1; n++) begin
      step(4'hF, 1'b1);
      if (last_acc) req_a[last_g] = 8'($urandom);
    end
    for (int n = 0; n < 3; n++) begin
      step(4'hF, 1'b0);
      if (n == 0) begin
        cap_d  = obs_d;
        cap_id = obs_id;
      end
      chk("bp_valid", 32'(obs_v), 32'd1);
      chk("bp_data", 32'(obs_d), 32'(cap_d));
      chk("bp_id", 32'(obs_id), 32'(cap_id));
      chk("bp_ready", 32'(obs_rr), 32'd0);
      modulant = 8'($urandom);
    end
    for (int n = 0; n < 4; n++) begin
      step(4'hF, 1'b1);
      if (last_acc) req_a[last_g] = 8'($urandom);
    end
    repeat (LAT + 1) step(4'h0, 1'b1);

    // Random traffic with protocol-respecting requesters.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i]  = 1'b1;
          req_a[i] = 8'($urandom);
          req_b[i] = 8'($urandom);
        end
      end
      modulant = 8'($urandom_range(255, 1));
      step(pend, $urandom_range(3, 0) != 0);
      if (last_acc) pend[last_g] = 1'b0;
    end
    for (int n = 0; n < 20 && pend != 0; n++) begin
      step(pend, 1'b1);
      if (last_acc) pend[last_g] = 1'b0;
    end
    repeat (LAT + 1) step(4'h0, 1'b1);
    chk("no_loss", 32'(n_pop), 32'(n_acc));

    // Asynchronous reset with a result held.
    req_a[0] = 8'd3;
    req_b[0] = 8'd5;
    modulant = 8'd17;
    step(4'b0001, 1'b0);
    repeat (LAT - 1) step(4'b0000, 1'b0);
    req_valid = 4'b1010;
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_data", 32'(rsp_data), 32'd15);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_data", 32'(rsp_data), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b1010, 1'b1);
    chk("post_rst_grant", 32'(obs_rr), 32'b0010);
    step(4'b1000, 1'b1);
    chk("post_rst_grant2", 32'(obs_rr), 32'b1000);
    repeat (LAT + 1) step(4'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
